// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispenser controller: request codes,
// controller states and the code-to-actuator mapping.
package vend_pkg;

  typedef logic [1:0] req_code_t;

  localparam req_code_t REQ_A   = 2'd0;
  localparam req_code_t REQ_B   = 2'd1;
  localparam req_code_t REQ_C   = 2'd2;
  localparam req_code_t REQ_CHG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_DONE,
    ST_FAULT
  } state_t;

  // Bit order of the returned vector: {hopper, motor_c, motor_b, motor_a}
  function automatic logic [3:0] code_to_act(input req_code_t code);
    logic [3:0] act;
    act = 4'b0000;
    act[code] = 1'b1;
    return act;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Small synchronous FIFO of 2-bit request codes. Pushes while full and pops
// while empty are ignored; dout shows the head entry whenever non-empty.
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  req_code_t din,
  input  logic      pop,
  output req_code_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  req_code_t      mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_dispenser_ctrl.sv
// Turns product/change request edges into timed actuator drives, confirms each
// delivery through the drop/coin sensors and flags a sticky fault on timeout.
module vend_dispenser_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_CYC   = 8,
  parameter int TIMEOUT_CYC = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PrA,
  input  logic             PrB,
  input  logic             PrC,
  input  logic             change,
  input  logic             drop_sense,
  input  logic             coin_sense,
  input  logic             fault_clr,
  output logic             motor_a,
  output logic             motor_b,
  output logic             motor_c,
  output logic             hopper_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             overflow,
  output logic [CNT_W-1:0] dispensed_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] MOTOR_LAST   = TW'(MOTOR_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [3:0]    req_in, req_prev, edge_v, pending, req_v, sel_1h;
  req_code_t     sel_code;
  logic          push, pop, full, empty;
  req_code_t     fifo_dout;

  state_t        state, state_d;
  req_code_t     code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sensed_q, sensed_d;
  logic          sense_match;
  logic [3:0]    act_q;

  assign req_in = {change, PrC, PrB, PrA};
  assign edge_v = req_in & ~req_prev;
  // A fresh edge may be enqueued in the same cycle it is detected
  assign req_v  = pending | edge_v;

  always_comb begin
    sel_1h   = 4'b0000;
    sel_code = REQ_A;
    if (req_v[0]) begin
      sel_1h   = 4'b0001;
      sel_code = REQ_A;
    end else if (req_v[1]) begin
      sel_1h   = 4'b0010;
      sel_code = REQ_B;
    end else if (req_v[2]) begin
      sel_1h   = 4'b0100;
      sel_code = REQ_C;
    end else if (req_v[3]) begin
      sel_1h   = 4'b1000;
      sel_code = REQ_CHG;
    end
  end

  assign push = (|req_v) & ~full;

  vend_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (sel_code),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign sense_match = (code_q == REQ_CHG) ? coin_sense : drop_sense;

  // timer_q counts cycles since the first DRIVE cycle of the current delivery
  always_comb begin
    state_d  = state;
    code_d   = code_q;
    timer_d  = timer_q;
    sensed_d = sensed_q;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          code_d   = fifo_dout;
          timer_d  = '0;
          sensed_d = 1'b0;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        sensed_d = sensed_q | sense_match;
        timer_d  = timer_q + 1'b1;
        if (timer_q == MOTOR_LAST) begin
          state_d = sensed_d ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (sense_match) begin
          state_d = ST_DONE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      code_q        <= REQ_A;
      timer_q       <= '0;
      sensed_q      <= 1'b0;
      act_q         <= 4'b0000;
      req_prev      <= 4'b0000;
      pending       <= 4'b0000;
      overflow      <= 1'b0;
      dispensed_cnt <= '0;
    end else begin
      state    <= state_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      sensed_q <= sensed_d;
      act_q    <= (state_d == ST_DRIVE) ? code_to_act(code_d) : 4'b0000;
      req_prev <= req_in;
      pending  <= req_v & ~(push ? sel_1h : 4'b0000);
      // A second edge on a source that is still pending is lost
      if (|(edge_v & pending)) begin
        overflow <= 1'b1;
      end
      if (state_d == ST_DONE) begin
        dispensed_cnt <= dispensed_cnt + 1'b1;
      end
    end
  end

  assign motor_a   = act_q[0];
  assign motor_b   = act_q[1];
  assign motor_c   = act_q[2];
  assign hopper_en = act_q[3];
  assign done      = (state == ST_DONE);
  assign fault     = (state == ST_FAULT);
  assign busy      = (state != ST_IDLE) | ~empty | (|pending);

endmodule

// File: tb/tb_vend_dispenser_ctrl.sv
// Bench for vend_dispenser_ctrl: a timing table, directed corner sequences and
// random traffic, all checked every cycle against a transaction-level model.
module tb_vend_dispenser_ctrl;

  localparam int MOTOR_CYC   = 8;
  localparam int TIMEOUT_CYC = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic PrA = 1'b0, PrB = 1'b0, PrC = 1'b0, change = 1'b0;
  logic drop_sense = 1'b0, coin_sense = 1'b0, fault_clr = 1'b0;
  logic motor_a, motor_b, motor_c, hopper_en, busy, done, fault, overflow;
  logic [CNT_W-1:0] dispensed_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vend_dispenser_ctrl #(
    .MOTOR_CYC(MOTOR_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .PrA(PrA), .PrB(PrB), .PrC(PrC), .change(change),
    .drop_sense(drop_sense), .coin_sense(coin_sense), .fault_clr(fault_clr),
    .motor_a(motor_a), .motor_b(motor_b), .motor_c(motor_c), .hopper_en(hopper_en),
    .busy(busy), .done(done), .fault(fault), .overflow(overflow),
    .dispensed_cnt(dispensed_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] dut_vec;
  assign dut_vec = {hopper_en, motor_c, motor_b, motor_a, done, busy, fault, overflow,
                    dispensed_cnt};

  task automatic check16(input string name, input int idx, input logic [15:0] got,
                         input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", name, idx, cyc, got, exp);
    end
  endtask

  // Reference model: request flags, a code queue and one delivery tracked by
  // its elapsed cycle count. Updated once per rising edge.
  int          q_m[$];
  bit [3:0]    m_prev, m_pend;
  int          m_job = -1;
  int          m_t;
  bit          m_sensed, m_fault, m_done, m_ovf, m_valid;
  logic [7:0]  m_cnt;

  always @(posedge clk) begin : ref_model
    bit [3:0] ins, e, req;
    int       push_code;
    ins = {change, PrC, PrB, PrA};
    if (reset) begin
      q_m.delete();
      m_prev = '0; m_pend = '0; m_job = -1; m_t = 0;
      m_sensed = 0; m_fault = 0; m_done = 0; m_ovf = 0; m_cnt = '0;
      m_valid = 1;
    end else begin
      e = ins & ~m_prev;
      if ((e & m_pend) != 0) m_ovf = 1;
      req = m_pend | e;
      push_code = -1;
      if (q_m.size() < FIFO_DEPTH)
        for (int i = 0; i < 4; i++)
          if (push_code < 0 && req[i]) push_code = i;
      if (m_fault) begin
        if (fault_clr) m_fault = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_job >= 0) begin
        if ((m_job == 3) ? coin_sense : drop_sense) m_sensed = 1;
        if (m_t < MOTOR_CYC - 1) m_t++;
        else if (m_sensed) begin m_done = 1; m_cnt++; m_job = -1; end
        else if (m_t == TIMEOUT_CYC - 1) begin m_fault = 1; m_job = -1; end
        else m_t++;
      end else if (q_m.size() > 0) begin
        m_job = q_m.pop_front(); m_t = 0; m_sensed = 0;
      end
      if (push_code >= 0) begin
        q_m.push_back(push_code);
        req[push_code] = 1'b0;
      end
      m_pend = req;
      m_prev = ins;
    end
  end

  function automatic logic [15:0] model_vec();
    logic [3:0] act;
    logic       mbusy;
    act = 4'b0000;
    if (m_job >= 0 && m_t < MOTOR_CYC) act = 4'b0001 << m_job;
    mbusy = (m_job >= 0) || m_fault || m_done || (q_m.size() > 0) || (m_pend != 0);
    return {act, m_done, mbusy, m_fault, m_ovf, m_cnt};
  endfunction

  // scoreboard: every cycle the DUT must match the model
  always @(negedge clk) begin
    if (m_valid) check16("model", cyc, dut_vec, model_vec());
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {PrA, PrB, PrC, change, drop_sense, coin_sense, fault_clr} = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_act(input int idx, input int limit, output int ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ({hopper_en, motor_c, motor_b, motor_a} & (4'b0001 << idx)) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check16("wait_act_timeout", idx, 16'd0, 16'd1);
  endtask

  typedef struct {
    logic        pra;
    logic        drop;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[23];

  initial begin : guard
    #2_000_000;
    errors++;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int ok, d0, hcnt, rises;
    logic [3:0] act_now, act_prev;
    logic [3:0] order[$];
    int on_cnt[4];
    bit overlap, glitch, held_off;

    // single A vend: PrA in cycle 10, drop in 15, motor 12..19, done 20
    for (int c = 0; c < 23; c++) begin
      vecs[c].pra  = (c == 10);
      vecs[c].drop = (c == 15);
      vecs[c].exp  = {1'b0, 1'b0, 1'b0, (c >= 12 && c <= 19), (c == 20),
                      (c >= 11 && c <= 20), 1'b0, 1'b0, (c >= 20) ? 8'd1 : 8'd0};
    end
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      check16("table", c, dut_vec, vecs[c].exp);
      PrA = vecs[c].pra;
      drop_sense = vecs[c].drop;
    end

    // A, C, CHG together: served in priority order, never overlapping
    do_reset();
    @(negedge clk);
    PrA = 1; PrC = 1; change = 1;
    act_prev = 4'b0000; overlap = 0;
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 2) begin PrA = 0; PrC = 0; change = 0; end
      act_now = {hopper_en, motor_c, motor_b, motor_a};
      if (act_now != 0 && act_prev == 0) order.push_back(act_now);
      if ($countones(act_now) > 1) overlap = 1;
      for (int i = 0; i < 4; i++) on_cnt[i] += act_now[i];
      drop_sense = motor_a | motor_c;
      coin_sense = hopper_en;
      act_prev = act_now;
    end
    check16("order_len", 0, 16'(order.size()), 16'd3);
    if (order.size() == 3) begin
      check16("order", 0, 16'(order[0]), 16'h1);
      check16("order", 1, 16'(order[1]), 16'h4);
      check16("order", 2, 16'(order[2]), 16'h8);
    end
    check16("on_a", 0, 16'(on_cnt[0]), 16'(MOTOR_CYC));
    check16("on_c", 0, 16'(on_cnt[2]), 16'(MOTOR_CYC));
    check16("on_hop", 0, 16'(on_cnt[3]), 16'(MOTOR_CYC));
    check16("overlap", 0, 16'(overlap), 16'd0);
    check16("cnt3", 0, 16'(dispensed_cnt), 16'd3);

    // change with no coin: timeout, PrB queued during FAULT, resume on clear
    do_reset();
    @(negedge clk); change = 1;
    @(negedge clk); change = 0;
    wait_act(3, 10, ok);
    d0 = cyc; hcnt = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (fault) break;
      hcnt += hopper_en;
    end
    check16("fault_time", 0, 16'(cyc - d0), 16'(TIMEOUT_CYC));
    check16("hop_len", 0, 16'(hcnt), 16'(MOTOR_CYC));
    @(negedge clk); PrB = 1;
    @(negedge clk); PrB = 0;
    held_off = 1;
    repeat (5) begin
      @(negedge clk);
      if (motor_b || !fault || !busy) held_off = 0;
    end
    check16("fault_hold", 0, 16'(held_off), 16'd1);
    fault_clr = 1;
    ok = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      fault_clr = 0;
      if (motor_b) ok = 1;
    end
    check16("clr_resume", 0, 16'(ok), 16'd1);
    drop_sense = 1;
    repeat (10) @(negedge clk);
    drop_sense = 0;
    check16("after_clr_cnt", 0, 16'(dispensed_cnt), 16'd1);

    // stalled delivery: FIFO fills, pending flags absorb, then overflow
    do_reset();
    @(negedge clk); change = 1;
    @(negedge clk); change = 0;
    wait_act(3, 10, ok);
    glitch = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) PrA = 1; else PrB = 1;
      if (motor_a || motor_b) glitch = 1;
      @(negedge clk);
      PrA = 0; PrB = 0;
      if (motor_a || motor_b) glitch = 1;
    end
    @(negedge clk);
    check16("ovf_before", 0, 16'(overflow), 16'd0);
    PrA = 1;
    @(negedge clk); PrA = 0;
    @(negedge clk);
    if (motor_a || motor_b) glitch = 1;
    check16("ovf_after", 0, 16'(overflow), 16'd1);
    check16("glitch", 0, 16'(glitch), 16'd0);

    // reset in the middle of a B drive
    do_reset();
    @(negedge clk); PrB = 1;
    @(negedge clk); PrB = 0;
    wait_act(1, 10, ok);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check16("rst_mid", 0, {7'd0, motor_b, busy, dispensed_cnt}, 16'd0);

    // PrA held high through reset release: exactly one vend
    @(negedge clk);
    PrA = 1; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    rises = 0; act_prev = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (motor_a && !act_prev[0]) rises++;
      act_prev = {3'b000, motor_a};
      drop_sense = motor_a;
    end
    PrA = 0; drop_sense = 0;
    check16("held_rises", 0, 16'(rises), 16'd1);
    check16("held_cnt", 0, 16'(dispensed_cnt), 16'd1);

    // drop_sense during CHG does not confirm it
    do_reset();
    @(negedge clk); change = 1;
    @(negedge clk); change = 0;
    wait_act(3, 10, ok);
    d0 = cyc;
    for (int k = 0; k < 60; k++) begin
      drop_sense = (k % 3 == 0);
      @(negedge clk);
      if (fault) break;
    end
    drop_sense = 0;
    check16("chg_drop_fault", 0, 16'(cyc - d0), 16'(TIMEOUT_CYC));
    check16("chg_drop_cnt", 0, 16'(dispensed_cnt), 16'd0);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) PrA = ~PrA;
      if ($urandom_range(0, 9) == 0) PrB = ~PrB;
      if ($urandom_range(0, 11) == 0) PrC = ~PrC;
      if ($urandom_range(0, 11) == 0) change = ~change;
      drop_sense = ($urandom_range(0, 7) == 0);
      coin_sense = ($urandom_range(0, 7) == 0);
      fault_clr  = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    {PrA, PrB, PrC, change, drop_sense, coin_sense, fault_clr, reset} = '0;
    repeat (5) @(negedge clk);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
